// File: rtl/register_cdc_scheduler.sv
// rtl/register_cdc_scheduler.sv - round-robin scheduler sharing one 4-phase req/ack CDC channel among N_CH registers
module register_cdc_scheduler #(
    parameter int N_CH    = 4,
    parameter int WIDTH   = 32,
    parameter int IDX_W   = 2,
    parameter int REFRESH = 1024
) (
    input  logic                    clk,
    input  logic                    resetn,
    input  logic [N_CH*WIDTH-1:0]   reg_in,
    output logic                    xfer_req,
    output logic [IDX_W+WIDTH-1:0]  xfer_data,
    input  logic                    xfer_ack,
    output logic [N_CH-1:0]         pending,
    output logic                    busy
);
    localparam int RW = (REFRESH > 1) ? $clog2(REFRESH) : 1;
    localparam logic [RW-1:0] CNT_LAST = (REFRESH > 0) ? RW'(REFRESH - 1) : '0;

    typedef enum logic [1:0] {S_IDLE, S_REQ, S_RELEASE} state_t;

    state_t                   state_q, state_d;
    logic [IDX_W-1:0]         rr_ptr_q, rr_ptr_d;
    logic [N_CH-1:0]          pend_q, pend_d;
    logic [N_CH*WIDTH-1:0]    shadow_q, shadow_d;
    logic                     req_q, req_d;
    logic [IDX_W+WIDTH-1:0]   data_q, data_d;
    logic [RW-1:0]            cnt_q, cnt_d;

    logic [IDX_W-1:0]         grant;
    logic [IDX_W-1:0]         cand;
    logic                     found;
    logic                     wrap;

    // Round-robin search starting at rr_ptr over registered pending flags only.
    always_comb begin
        grant = '0;
        cand  = '0;
        found = 1'b0;
        for (int k = 0; k < N_CH; k++) begin
            cand = IDX_W'((int'(rr_ptr_q) + k) % N_CH);
            if (!found && pend_q[cand]) begin
                found = 1'b1;
                grant = cand;
            end
        end
    end

    assign wrap = (REFRESH != 0) && (cnt_q == CNT_LAST);

    always_comb begin
        state_d  = state_q;
        rr_ptr_d = rr_ptr_q;
        pend_d   = pend_q;
        shadow_d = shadow_q;
        req_d    = req_q;
        data_d   = data_q;
        cnt_d    = (REFRESH == 0 || wrap) ? '0 : cnt_q + 1'b1;

        for (int i = 0; i < N_CH; i++) begin
            if (reg_in[i*WIDTH +: WIDTH] != shadow_q[i*WIDTH +: WIDTH]) begin
                pend_d[i] = 1'b1;
            end
        end

        case (state_q)
            S_IDLE: begin
                if (found && !xfer_ack) begin
                    data_d   = {grant, reg_in[int'(grant)*WIDTH +: WIDTH]};
                    shadow_d[int'(grant)*WIDTH +: WIDTH] = reg_in[int'(grant)*WIDTH +: WIDTH];
                    pend_d[grant] = 1'b0;
                    rr_ptr_d = IDX_W'((int'(grant) + 1) % N_CH);
                    req_d    = 1'b1;
                    state_d  = S_REQ;
                end
            end
            S_REQ: begin
                if (xfer_ack) begin
                    req_d   = 1'b0;
                    state_d = S_RELEASE;
                end
            end
            S_RELEASE: begin
                if (!xfer_ack) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                req_d   = 1'b0;
                state_d = S_IDLE;
            end
        endcase

        // Refresh outranks the capture clear so a just-sent channel is queued again.
        if (wrap) begin
            pend_d = '1;
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q  <= S_IDLE;
            rr_ptr_q <= '0;
            pend_q   <= '1;
            shadow_q <= '0;
            req_q    <= 1'b0;
            data_q   <= '0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            rr_ptr_q <= rr_ptr_d;
            pend_q   <= pend_d;
            shadow_q <= shadow_d;
            req_q    <= req_d;
            data_q   <= data_d;
            cnt_q    <= cnt_d;
        end
    end

    assign xfer_req  = req_q;
    assign xfer_data = data_q;
    assign pending   = pend_q;
    assign busy      = (state_q != S_IDLE);
endmodule

// File: tb/tb_register_cdc_scheduler.sv
// tb/tb_register_cdc_scheduler.sv - directed self-checking bench for register_cdc_scheduler
module tb_register_cdc_scheduler;
    logic         clk;
    logic         resetn_a, resetn_b;
    logic [127:0] reg_in_a, reg_in_b;
    logic         req_a, req_b, ack_a, ack_b;
    logic [33:0]  data_a, data_b;
    logic [3:0]   pending_a, pending_b;
    logic         busy_a, busy_b;

    logic         ack_auto, ack_man;
    logic [2:0]   sh;
    int           cyc = 0;
    int           total = 0;
    int           passed = 0;
    int           stab_err = 0;

    logic [31:0]  cur [4];
    logic [31:0]  vb [4];

    logic [1:0]   qa_idx [$];
    logic [33:0]  qa_data [$];
    logic [1:0]   qb_idx [$];
    logic [33:0]  qb_data [$];
    int           qb_cyc [$];
    logic         prev_a = 1'b0, prev_b = 1'b0;
    logic [33:0]  prev_data_a = '0;

    register_cdc_scheduler #(.N_CH(4), .WIDTH(32), .IDX_W(2), .REFRESH(0)) dut_a (
        .clk(clk), .resetn(resetn_a), .reg_in(reg_in_a), .xfer_req(req_a),
        .xfer_data(data_a), .xfer_ack(ack_a), .pending(pending_a), .busy(busy_a)
    );

    register_cdc_scheduler #(.N_CH(4), .WIDTH(32), .IDX_W(2), .REFRESH(16)) dut_b (
        .clk(clk), .resetn(resetn_b), .reg_in(reg_in_b), .xfer_req(req_b),
        .xfer_data(data_b), .xfer_ack(ack_b), .pending(pending_b), .busy(busy_b)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Channel A: ack echoes req three cycles late; channel B: zero-latency ack.
    always @(posedge clk) begin
        sh  <= {sh[1:0], req_a};
        cyc <= cyc + 1;
    end
    assign ack_a = ack_auto ? sh[2] : ack_man;
    assign ack_b = req_b;

    always @(negedge clk) begin
        if (req_a && !prev_a) begin
            qa_idx.push_back(data_a[33:32]);
            qa_data.push_back(data_a);
        end
        if (req_a && prev_a && data_a != prev_data_a) stab_err <= stab_err + 1;
        if (req_b && !prev_b) begin
            qb_idx.push_back(data_b[33:32]);
            qb_data.push_back(data_b);
            qb_cyc.push_back(cyc);
        end
        prev_a      <= req_a;
        prev_b      <= req_b;
        prev_data_a <= data_a;
    end

    typedef struct {
        int          ch;
        logic [31:0] val;
        logic [3:0]  exp_pend;
        logic [33:0] exp_data;
    } vec_t;
    vec_t vecs [4];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h expected %h", nm, act, exp);
    endtask

    task automatic set_ch(input int ch, input logic [31:0] v);
        reg_in_a[ch*32 +: 32] = v;
        cur[ch] = v;
    endtask

    task automatic clear_qa();
        qa_idx.delete();
        qa_data.delete();
    endtask

    task automatic wait_idle(input string nm);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!(busy_a == 1'b0 && pending_a == 4'b0) && n < 300);
        chk({nm, "_idle_timeout"}, 64'(n < 300), 64'd1);
    endtask

    task automatic finish_manual(input string nm);
        int n;
        ack_man = 1'b1;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (req_a && n < 20);
        chk({nm, "_req_drop_timeout"}, 64'(n < 20), 64'd1);
        ack_man = 1'b0;
        @(negedge clk);
        ack_auto = 1'b1;
    endtask

    task automatic check_all_four(input string nm);
        chk({nm, "_count"}, 64'(qa_idx.size()), 64'd4);
        for (int i = 0; i < 4; i++) begin
            if (i < qa_idx.size()) begin
                chk({nm, "_idx"}, 64'(qa_idx[i]), 64'(i));
                chk({nm, "_data"}, 64'(qa_data[i]), 64'({i[1:0], cur[i]}));
            end
        end
    endtask

    int          c0;
    int          exp_b_idx [13];
    int          exp_b_cyc [13];
    logic [33:0] eb;

    initial begin
        vecs[0] = '{2, 32'hDEADBEEF, 4'b0100, {2'd2, 32'hDEADBEEF}};
        vecs[1] = '{0, 32'h12345678, 4'b0001, {2'd0, 32'h12345678}};
        vecs[2] = '{3, 32'hFFFFFFFF, 4'b1000, {2'd3, 32'hFFFFFFFF}};
        vecs[3] = '{1, 32'h00000000, 4'b0010, {2'd1, 32'h00000000}};
        exp_b_idx = '{0, 1, 2, 3, 0, 1, 2, 3, 1, 2, 3, 0, 1};
        exp_b_cyc = '{1, 4, 7, 10, 17, 20, 23, 26, 32, 35, 38, 41, 44};

        resetn_a = 1'b0;
        resetn_b = 1'b0;
        ack_auto = 1'b1;
        ack_man  = 1'b0;
        for (int i = 0; i < 4; i++) begin
            set_ch(i, 32'h11111111 * (i + 1));
            vb[i] = 32'hA0A0A0A0 + 32'(i);
            reg_in_b[i*32 +: 32] = vb[i];
        end

        // Reset state, then the four post-reset transfers in index order.
        repeat (3) @(negedge clk);
        chk("rst_req", 64'(req_a), 64'd0);
        chk("rst_data", 64'(data_a), 64'd0);
        chk("rst_pending", 64'(pending_a), 64'hF);
        chk("rst_busy", 64'(busy_a), 64'd0);
        clear_qa();
        resetn_a = 1'b1;
        wait_idle("t1");
        check_all_four("t1");
        chk("t1_pending_zero", 64'(pending_a), 64'd0);

        // Single-channel change: pending next edge, req the edge after, one transfer.
        for (int v = 0; v < 4; v++) begin
            @(negedge clk);
            set_ch(vecs[v].ch, vecs[v].val);
            clear_qa();
            @(negedge clk);
            chk($sformatf("vec%0d_pend", v), 64'(pending_a), 64'(vecs[v].exp_pend));
            chk($sformatf("vec%0d_req_early", v), 64'(req_a), 64'd0);
            @(negedge clk);
            chk($sformatf("vec%0d_req", v), 64'(req_a), 64'd1);
            chk($sformatf("vec%0d_data", v), 64'(data_a), 64'(vecs[v].exp_data));
            wait_idle($sformatf("vec%0d", v));
            chk($sformatf("vec%0d_count", v), 64'(qa_idx.size()), 64'd1);
        end

        // rr_ptr is now 2: ch1+ch3 pending grant 3 then 1, leaving rr_ptr at 2.
        @(negedge clk);
        set_ch(1, 32'h01010101);
        set_ch(3, 32'h03030303);
        clear_qa();
        repeat (2) @(negedge clk);
        wait_idle("rr1");
        chk("rr1_count", 64'(qa_idx.size()), 64'd2);
        if (qa_idx.size() == 2) begin
            chk("rr1_first", 64'(qa_idx[0]), 64'd3);
            chk("rr1_second", 64'(qa_idx[1]), 64'd1);
        end
        set_ch(0, 32'h0A0A0A0A);
        set_ch(2, 32'h02020202);
        clear_qa();
        repeat (2) @(negedge clk);
        wait_idle("rr2");
        chk("rr2_count", 64'(qa_idx.size()), 64'd2);
        if (qa_idx.size() == 2) begin
            chk("rr2_first", 64'(qa_idx[0]), 64'd2);
            chk("rr2_second", 64'(qa_idx[1]), 64'd0);
        end

        // Stale ack held high in IDLE blocks launch until it falls.
        ack_auto = 1'b0;
        ack_man  = 1'b1;
        @(negedge clk);
        set_ch(3, 32'h5A5A5A5A);
        clear_qa();
        repeat (5) @(negedge clk);
        chk("stale_req", 64'(req_a), 64'd0);
        chk("stale_pending", 64'(pending_a), 64'b1000);
        chk("stale_busy", 64'(busy_a), 64'd0);
        ack_man = 1'b0;
        @(negedge clk);
        chk("stale_launch", 64'(req_a), 64'd1);
        chk("stale_data", 64'(data_a), 64'({2'd3, 32'h5A5A5A5A}));
        finish_manual("stale");
        wait_idle("stale");

        // ch0 changes every cycle through a 10-cycle REQ.
        ack_auto = 1'b0;
        ack_man  = 1'b0;
        @(negedge clk);
        set_ch(0, 32'h00001000);
        clear_qa();
        stab_err = 0;
        repeat (2) @(negedge clk);
        chk("frz_req", 64'(req_a), 64'd1);
        chk("frz_data0", 64'(data_a), 64'({2'd0, 32'h00001000}));
        for (int k = 1; k <= 10; k++) begin
            @(negedge clk);
            set_ch(0, 32'h00001000 + 32'(k));
        end
        finish_manual("frz");
        wait_idle("frz");
        chk("frz_stable", 64'(stab_err), 64'd0);
        chk("frz_count", 64'(qa_idx.size()), 64'd2);
        if (qa_idx.size() == 2) chk("frz_last", 64'(qa_data[1]), 64'({2'd0, 32'h0000100A}));

        // Reset during REQ with no ack: req drops next cycle, full resend from index 0.
        ack_auto = 1'b0;
        ack_man  = 1'b0;
        @(negedge clk);
        set_ch(2, 32'h77777777);
        repeat (3) @(negedge clk);
        chk("mid_req_before", 64'(req_a), 64'd1);
        resetn_a = 1'b0;
        clear_qa();
        @(negedge clk);
        chk("mid_req_after", 64'(req_a), 64'd0);
        chk("mid_pending", 64'(pending_a), 64'hF);
        chk("mid_busy", 64'(busy_a), 64'd0);
        chk("mid_data", 64'(data_a), 64'd0);
        resetn_a = 1'b1;
        ack_auto = 1'b1;
        wait_idle("mid");
        check_all_four("mid");

        // REFRESH=16 with zero-latency ack; a change lands a capture on the wrap edge.
        @(negedge clk);
        resetn_b = 1'b1;
        c0 = cyc;
        qb_idx.delete();
        qb_data.delete();
        qb_cyc.delete();
        while (cyc - c0 < 45) begin
            @(negedge clk);
            if (cyc - c0 == 30) reg_in_b[1*32 +: 32] = 32'hCAFEF00D;
            if (cyc - c0 == 32) chk("ref_collide_pending", 64'(pending_b), 64'hF);
        end
        chk("ref_count", 64'(qb_idx.size()), 64'd13);
        for (int k = 0; k < 13; k++) begin
            if (k < qb_idx.size()) begin
                eb = {2'(exp_b_idx[k]), (k >= 8 && exp_b_idx[k] == 1) ? 32'hCAFEF00D : vb[exp_b_idx[k]]};
                chk($sformatf("ref%0d_idx", k), 64'(qb_idx[k]), 64'(exp_b_idx[k]));
                chk($sformatf("ref%0d_cyc", k), 64'(qb_cyc[k] - c0), 64'(exp_b_cyc[k]));
                chk($sformatf("ref%0d_data", k), 64'(qb_data[k]), 64'(eb));
            end
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
